// File: rtl/sort_pkg.sv
// Shared defaults and types for the selection-sort engine, its result checker and the top level.
package sort_pkg;

  localparam int unsigned ADDR_W  = 8;
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned N_ELEM  = 256;
  localparam int unsigned CKSUM_W = 16;

  typedef enum logic [1:0] {
    StIdle,
    StScan,
    StDrain,
    StDone
  } chk_state_e;

endpackage

// File: rtl/sort_result_checker_if.sv
// Handshake and read-port bundle between the result checker and the data memory / top level.
interface sort_result_checker_if #(
  parameter int unsigned ADDR_W = sort_pkg::ADDR_W,
  parameter int unsigned DATA_W = sort_pkg::DATA_W
);

  logic              start;
  logic              rdy;
  logic              done;
  logic [DATA_W-1:0] rddata;
  logic [ADDR_W-1:0] addr;
  logic              wren;

  modport master (
    input  start,
    input  rddata,
    output rdy,
    output done,
    output addr,
    output wren
  );

  modport slave (
    output start,
    output rddata,
    input  rdy,
    input  done,
    input  addr,
    input  wren
  );

endinterface

// File: rtl/sort_stat_accum.sv
// Running statistics over a word stream: order check, first violation, checksum, min and max.
module sort_stat_accum #(
  parameter int unsigned ADDR_W  = sort_pkg::ADDR_W,
  parameter int unsigned DATA_W  = sort_pkg::DATA_W,
  parameter int unsigned CKSUM_W = sort_pkg::CKSUM_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               en,
  input  logic               first,
  input  logic [ADDR_W-1:0]  idx,
  input  logic [DATA_W-1:0]  d,
  output logic               sorted,
  output logic [ADDR_W-1:0]  viol_idx,
  output logic [CKSUM_W-1:0] checksum,
  output logic [DATA_W-1:0]  min_val,
  output logic [DATA_W-1:0]  max_val
);

  logic [DATA_W-1:0]  prev_q;
  logic               sorted_q;
  logic [ADDR_W-1:0]  viol_q;
  logic [CKSUM_W-1:0] cksum_q;
  logic [DATA_W-1:0]  min_q;
  logic [DATA_W-1:0]  max_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q   <= '0;
      sorted_q <= 1'b0;
      viol_q   <= '0;
      cksum_q  <= '0;
      min_q    <= '0;
      max_q    <= '0;
    end else if (clear) begin
      prev_q   <= '0;
      sorted_q <= 1'b1;
      viol_q   <= '0;
      cksum_q  <= '0;
      min_q    <= '1;
      max_q    <= '0;
    end else if (en) begin
      prev_q  <= d;
      cksum_q <= cksum_q + CKSUM_W'(d);
      if (d < min_q) min_q <= d;
      if (d > max_q) max_q <= d;
      // Only the first descent is recorded; later ones leave viol_idx alone.
      if (!first && (d < prev_q) && sorted_q) begin
        sorted_q <= 1'b0;
        viol_q   <= idx;
      end
    end
  end

  assign sorted   = sorted_q;
  assign viol_idx = viol_q;
  assign checksum = cksum_q;
  assign min_val  = min_q;
  assign max_val  = max_q;

endmodule

// File: rtl/sort_result_checker.sv
// Scans N_ELEM words of the data memory after sorting and reports order, checksum and range.
module sort_result_checker #(
  parameter int unsigned ADDR_W = sort_pkg::ADDR_W,
  parameter int unsigned DATA_W = sort_pkg::DATA_W,
  parameter int unsigned N_ELEM = sort_pkg::N_ELEM
) (
  input  logic                        clk,
  input  logic                        rst,
  sort_result_checker_if.master       bus,
  output logic                        sorted,
  output logic [ADDR_W-1:0]           viol_idx,
  output logic [sort_pkg::CKSUM_W-1:0] checksum,
  output logic [DATA_W-1:0]           min_val,
  output logic [DATA_W-1:0]           max_val,
  output logic                        result_valid
);

  import sort_pkg::*;

  // Terminal compare so N_ELEM == 2**ADDR_W never relies on the counter wrapping.
  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(N_ELEM - 1);

  chk_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] idx_q;
  logic              rd_valid_q;
  logic              result_valid_q;
  logic              accept;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    accept  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d = StScan;
          addr_d  = '0;
          accept  = 1'b1;
        end
      end
      StScan: begin
        if (addr_q == LastAddr) state_d = StDrain;
        else                    addr_d  = addr_q + 1'b1;
      end
      StDrain: state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // rd_valid_q/idx_q track the one-cycle memory latency: data for idx_q is on rddata now.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StIdle;
      addr_q         <= '0;
      idx_q          <= '0;
      rd_valid_q     <= 1'b0;
      result_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      idx_q      <= addr_q;
      rd_valid_q <= (state_q == StScan);
      if (accept)                      result_valid_q <= 1'b0;
      else if (state_q == StDrain)     result_valid_q <= 1'b1;
    end
  end

  assign bus.rdy      = (state_q == StIdle);
  assign bus.done     = (state_q == StDone);
  assign bus.addr     = addr_q;
  assign bus.wren     = 1'b0;
  assign result_valid = result_valid_q;

  sort_stat_accum #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .CKSUM_W (CKSUM_W)
  ) u_accum (
    .clk      (clk),
    .rst      (rst),
    .clear    (accept),
    .en       (rd_valid_q),
    .first    (idx_q == '0),
    .idx      (idx_q),
    .d        (bus.rddata),
    .sorted   (sorted),
    .viol_idx (viol_idx),
    .checksum (checksum),
    .min_val  (min_val),
    .max_val  (max_val)
  );

endmodule

// File: tb/tb_sort_result_checker.sv
// Randomised self-checking bench for sort_result_checker against a whole-array reference model.
module tb_sort_result_checker;
  import sort_pkg::*;

  localparam int N = 256;

  logic CLOCK_50 = 1'b0;
  logic rst;
  always #10 CLOCK_50 = ~CLOCK_50;

  sort_result_checker_if bus ();
  sort_result_checker_if bus1 ();

  logic        sorted, sorted1, result_valid, result_valid1;
  logic [7:0]  viol_idx, viol_idx1, min_val, min_val1, max_val, max_val1;
  logic [15:0] checksum, checksum1;

  logic [7:0] mem [N];
  logic [7:0] mem1;

  always @(posedge CLOCK_50) begin
    bus.rddata  <= mem[bus.addr];
    bus1.rddata <= mem1;
  end

  sort_result_checker u_dut (
    .clk          (CLOCK_50),
    .rst          (rst),
    .bus          (bus),
    .sorted       (sorted),
    .viol_idx     (viol_idx),
    .checksum     (checksum),
    .min_val      (min_val),
    .max_val      (max_val),
    .result_valid (result_valid)
  );

  sort_result_checker #(.N_ELEM(1)) u_dut1 (
    .clk          (CLOCK_50),
    .rst          (rst),
    .bus          (bus1),
    .sorted       (sorted1),
    .viol_idx     (viol_idx1),
    .checksum     (checksum1),
    .min_val      (min_val1),
    .max_val      (max_val1),
    .result_valid (result_valid1)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    int srt;
    int viol;
    int cks;
    int mn;
    int mx;
  } exp_t;

  function automatic exp_t model();
    exp_t e;
    e.srt = 1; e.viol = 0; e.cks = 0; e.mn = 255; e.mx = 0;
    for (int i = 0; i < N; i++) begin
      e.cks = (e.cks + int'(mem[i])) % 65536;
      if (int'(mem[i]) < e.mn) e.mn = int'(mem[i]);
      if (int'(mem[i]) > e.mx) e.mx = int'(mem[i]);
      if (e.srt == 1 && i > 0 && mem[i] < mem[i-1]) begin
        e.srt  = 0;
        e.viol = i;
      end
    end
    return e;
  endfunction

  task automatic check_results(input string tag, input exp_t e);
    check_val({tag, "/sorted"}, sorted, e.srt);
    check_val({tag, "/viol_idx"}, viol_idx, e.viol);
    check_val({tag, "/checksum"}, checksum, e.cks);
    check_val({tag, "/min_val"}, min_val, e.mn);
    check_val({tag, "/max_val"}, max_val, e.mx);
    check_val({tag, "/result_valid"}, result_valid, 1);
  endtask

  task automatic check_reset(input string tag);
    check_val({tag, "/rdy"}, bus.rdy, 1);
    check_val({tag, "/done"}, bus.done, 0);
    check_val({tag, "/addr"}, bus.addr, 0);
    check_val({tag, "/wren"}, bus.wren, 0);
    check_val({tag, "/sorted"}, sorted, 0);
    check_val({tag, "/viol_idx"}, viol_idx, 0);
    check_val({tag, "/checksum"}, checksum, 0);
    check_val({tag, "/min_val"}, min_val, 0);
    check_val({tag, "/max_val"}, max_val, 0);
    check_val({tag, "/result_valid"}, result_valid, 0);
  endtask

  // abort_at>0: assert rst in cycle E0+abort_at. poke_at>0: pulse start in cycle E0+poke_at.
  // hold: keep start high so a second scan begins right after the first.
  task automatic run_scan(input string tag, input int abort_at, input int poke_at, input bit hold);
    exp_t e;
    int addr_err = 0, wren_err = 0, done_cnt = 0, done_at = -1, waited;
    e = model();
    @(negedge CLOCK_50);
    check_val({tag, "/rdy_pre"}, bus.rdy, 1);
    bus.start = 1'b1;
    @(posedge CLOCK_50);
    #1;
    if (!hold) bus.start = 1'b0;
    for (int k = 1; k <= N + 3; k++) begin
      @(negedge CLOCK_50);
      if (abort_at > 0 && k == abort_at + 1) begin
        rst = 1'b0;
        check_reset({tag, "/abort"});
        check_val({tag, "/abort_no_done"}, done_cnt, 0);
        return;
      end
      if (poke_at > 0 && k == poke_at) bus.start = 1'b1;
      if (poke_at > 0 && k == poke_at + 1) bus.start = 1'b0;
      if (bus.wren !== 1'b0) wren_err++;
      if (k <= N && bus.addr !== 8'(k - 1)) addr_err++;
      if (bus.done === 1'b1) begin
        done_cnt++;
        if (done_at < 0) done_at = k;
      end
      if (k == abort_at) rst = 1'b1;
      if (k == N + 2) check_results(tag, e);
      if (k == N + 3) check_val({tag, "/rdy_post"}, bus.rdy, 1);
    end
    check_val({tag, "/addr_seq_errs"}, addr_err, 0);
    check_val({tag, "/wren_errs"}, wren_err, 0);
    check_val({tag, "/done_pulses"}, done_cnt, 1);
    check_val({tag, "/done_cycle"}, done_at, N + 2);
    if (hold) begin
      @(negedge CLOCK_50);
      check_val({tag, "/restart_rdy"}, bus.rdy, 0);
      check_val({tag, "/restart_addr"}, bus.addr, 0);
      check_val({tag, "/restart_rv_clear"}, result_valid, 0);
      bus.start = 1'b0;
      waited = 0;
      while (bus.done !== 1'b1 && waited < N + 10) begin
        @(negedge CLOCK_50);
        waited++;
      end
      check_val({tag, "/restart_timeout"}, (waited < N + 10), 1);
      check_results({tag, "/restart"}, e);
      @(negedge CLOCK_50);
    end
  endtask

  task automatic run_single(input string tag, input logic [7:0] w);
    int done_at = -1;
    mem1 = w;
    @(negedge CLOCK_50);
    check_val({tag, "/rdy_pre"}, bus1.rdy, 1);
    bus1.start = 1'b1;
    @(posedge CLOCK_50);
    #1;
    bus1.start = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge CLOCK_50);
      if (k == 1) check_val({tag, "/addr"}, bus1.addr, 0);
      if (bus1.done === 1'b1 && done_at < 0) done_at = k;
      if (k == 3) begin
        check_val({tag, "/sorted"}, sorted1, 1);
        check_val({tag, "/viol_idx"}, viol_idx1, 0);
        check_val({tag, "/checksum"}, checksum1, {8'h00, w});
        check_val({tag, "/min_val"}, min_val1, w);
        check_val({tag, "/max_val"}, max_val1, w);
        check_val({tag, "/result_valid"}, result_valid1, 1);
      end
    end
    check_val({tag, "/done_cycle"}, done_at, 3);
  endtask

  initial begin
    int v;
    rst         = 1'b1;
    bus.start   = 1'b0;
    bus1.start  = 1'b0;
    bus.rddata  = '0;
    bus1.rddata = '0;
    mem1        = '0;
    for (int i = 0; i < N; i++) mem[i] = 8'(i);
    repeat (3) @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    check_reset("reset");
    rst = 1'b0;

    run_scan("ascend", 0, 0, 1'b0);

    for (int i = 0; i < N; i++) mem[i] = 8'(255 - i);
    run_scan("descend", 0, 0, 1'b0);

    for (int i = 0; i < N; i++) mem[i] = 8'h42;
    run_scan("const42", 0, 0, 1'b0);

    for (int i = 0; i < N; i++) mem[i] = 8'(i);
    mem[200] = 8'd0;
    mem[201] = 8'd5;
    run_scan("patch", 0, 0, 1'b0);
    run_scan("poke_busy", 0, 50, 1'b0);

    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < N; i++) mem[i] = 8'($urandom_range(0, 255));
      run_scan("rand", 0, 0, 1'b0);
    end

    v = 0;
    for (int i = 0; i < N; i++) begin
      v = v + int'($urandom_range(0, 1));
      mem[i] = 8'((v > 255) ? 255 : v);
    end
    run_scan("rand_sorted", 0, 0, 1'b0);
    mem[$urandom_range(1, 255)] = 8'd0;
    run_scan("rand_dip", 0, 0, 1'b0);

    for (int i = 0; i < N; i++) mem[i] = 8'($urandom_range(0, 255));
    run_scan("abort", 100, 0, 1'b0);
    run_scan("after_abort", 0, 0, 1'b0);
    run_scan("hold_start", 0, 0, 1'b1);

    run_single("n1_a", 8'($urandom_range(0, 255)));
    run_single("n1_b", 8'hFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
